// File: rtl/weight_bram_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// weight_bram_sequencer_pkg : shared ANN weight-memory constants and the
// sequencer state type reused by layer-level sequencers.          Rev 1.0
// ============================================================================
package weight_bram_sequencer_pkg;

    localparam int WEIGHT_W    = 16;
    localparam int BRAM_DEPTH  = 28;
    localparam int BRAM_ADDR_W = 5;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/weight_out_fifo.sv
`default_nettype none
// ============================================================================
// weight_out_fifo : 2-entry synchronous FIFO with registered head output.
//                                                                 Rev 1.0
// ============================================================================
module weight_out_fifo
    import weight_bram_sequencer_pkg::*;
#(
    parameter int WIDTH = BRAM_ADDR_W + WEIGHT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] tail;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop && (count != 2'd0);
    assign push_ok = push && ((count != 2'd2) || pop_ok);

    // The head entry is a register of its own so the consumer sees a
    // flop output rather than a pointer-selected mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/weight_bram_sequencer.sv
`default_nettype none
// ============================================================================
// weight_bram_sequencer : arbitrates loader writes against a streamed read
// pass of one neuron weight BRAM toward the MAC.                  Rev 1.0
// ============================================================================
module weight_bram_sequencer
    import weight_bram_sequencer_pkg::*;
#(
    parameter int DEPTH  = BRAM_DEPTH,
    parameter int ADDR_W = BRAM_ADDR_W,
    parameter int DATA_W = WEIGHT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    output logic              BUSY,
    output logic              DONE,
    input  logic              LD_REQ,
    input  logic [ADDR_W-1:0] LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_ACK,
    output logic              BRAM_EN,
    output logic              BRAM_WE,
    output logic [ADDR_W-1:0] BRAM_ADDR,
    output logic [DATA_W-1:0] BRAM_DI,
    input  logic [DATA_W-1:0] BRAM_DO,
    output logic [DATA_W-1:0] W_OUT,
    output logic [ADDR_W-1:0] W_IDX,
    output logic              W_VALID,
    input  logic              W_READY
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    seq_state_t                 state;
    seq_state_t                 state_next;
    logic [ADDR_W-1:0]          rd_cnt;
    logic [1:0]                 occupancy;
    logic [2:0]                 level;
    logic                       in_flight;
    logic                       pop;
    logic                       issue;
    logic                       done_next;
    logic                       wr_in_range;
    logic [ADDR_W+DATA_W-1:0]   fifo_head;

    // A read issued last cycle is identified by BRAM_EN without BRAM_WE;
    // its data and address are pushed together at this posedge.
    assign in_flight   = BRAM_EN & ~BRAM_WE;
    assign W_VALID     = (occupancy != 2'd0);
    assign pop         = W_VALID & W_READY;
    assign {W_IDX, W_OUT} = fifo_head;
    assign wr_in_range = ({1'b0, LD_ADDR} < DEPTH_EXT);
    assign level       = {1'b0, occupancy} - {2'b00, pop} + {2'b00, in_flight};

    weight_out_fifo #(
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (in_flight),
        .push_data ({BRAM_ADDR, BRAM_DO}),
        .pop       (pop),
        .head      (fifo_head),
        .count     (occupancy)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SEQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done_next  = 1'b0;
        LD_ACK     = 1'b0;
        case (state)
            SEQ_IDLE: begin
                // A pending load always beats START; START is simply dropped.
                if (LD_REQ) begin
                    LD_ACK = ~RST;
                end else if (START) begin
                    state_next = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                if (level < 3'd2) begin
                    issue = 1'b1;
                    if (rd_cnt == LAST_ADDR) begin
                        state_next = SEQ_DRAIN;
                    end
                end
            end
            SEQ_DRAIN: begin
                if (level == 3'd0) begin
                    state_next = SEQ_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_cnt    <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            BRAM_EN   <= 1'b0;
            BRAM_WE   <= 1'b0;
            BRAM_ADDR <= '0;
            BRAM_DI   <= '0;
        end else begin
            BUSY    <= (state_next != SEQ_IDLE);
            DONE    <= done_next;
            BRAM_EN <= 1'b0;
            BRAM_WE <= 1'b0;
            if (LD_ACK) begin
                if (wr_in_range) begin
                    BRAM_EN   <= 1'b1;
                    BRAM_WE   <= 1'b1;
                    BRAM_ADDR <= LD_ADDR;
                    BRAM_DI   <= LD_DATA;
                end
            end else if (issue) begin
                BRAM_EN   <= 1'b1;
                BRAM_ADDR <= rd_cnt;
                rd_cnt    <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
